// File: rtl/dm_pkg.sv
// Shared definitions for the synchronous data memory.
// Holds the clear-sequencer state type, the lane-count helper and a
// clog2 helper that never returns less than one bit.
package dm_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } dm_state_t;

  // Number of independently writable lanes in one word.
  function automatic int lane_count(input int data_length, input int lane_width);
    return data_length / lane_width;
  endfunction

  // Width needed to index n entries; a one-word memory still gets a 1-bit index.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dm_clear_seq.sv
// Post-reset clear sequencer for dm_ram_sync.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-high reset
//   busy     - high while the clear sequence runs
//   clr_addr - word currently being zeroed
//   clr_we   - write strobe for the clear port
module dm_clear_seq
  import dm_pkg::*;
#(
  parameter int MEM_SIZE       = 16,
  parameter int CLEAR_ON_RESET = 1,
  parameter int CNT_W          = clog2_min1(MEM_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             busy,
  output logic [CNT_W-1:0] clr_addr,
  output logic             clr_we
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_SIZE - 1);

  dm_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_CLEAR: begin
        if (cnt == LAST) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state == ST_CLEAR);
  assign clr_we   = (state == ST_CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/dm_ram_sync.sv
// Synchronous single-port data memory with registered reads, byte-lane
// writes, out-of-range detection and an optional post-reset clear.
// Ports:
//   i_clk, i_reset - clock and asynchronous active-high reset
//   i_addr         - word address
//   i_wr, i_rd     - write / read requests sampled at the rising edge
//   i_be           - lane write enables
//   i_data         - write data
//   o_data         - read data (0 unless o_valid)
//   o_valid        - one-cycle read-data strobe
//   o_busy         - clear sequence in progress, requests ignored
//   o_err          - one-cycle strobe for an out-of-range request
module dm_ram_sync
  import dm_pkg::*;
#(
  parameter int MEM_SIZE       = 16,
  parameter int ADDR_LENGTH    = 11,
  parameter int DATA_LENGTH    = 16,
  parameter int LANE_WIDTH     = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic [ADDR_LENGTH-1:0]              i_addr,
  input  logic                                i_wr,
  input  logic                                i_rd,
  input  logic [DATA_LENGTH/LANE_WIDTH-1:0]   i_be,
  input  logic [DATA_LENGTH-1:0]              i_data,
  output logic [DATA_LENGTH-1:0]              o_data,
  output logic                                o_valid,
  output logic                                o_busy,
  output logic                                o_err
);

  localparam int LANES = lane_count(DATA_LENGTH, LANE_WIDTH);
  localparam int IDX_W = clog2_min1(MEM_SIZE);

  logic [DATA_LENGTH-1:0] mem [MEM_SIZE];

  logic                   busy;
  logic                   clr_we;
  logic [IDX_W-1:0]       clr_addr;
  logic [IDX_W-1:0]       idx;
  logic                   in_range;
  logic                   cpu_we;
  logic                   cpu_rd;
  logic [DATA_LENGTH-1:0] wmerge;

  logic [DATA_LENGTH-1:0] rdata_p1;
  logic                   vld_p1;
  logic                   err_p1;

  dm_clear_seq #(
    .MEM_SIZE       (MEM_SIZE),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .CNT_W          (IDX_W)
  ) u_clear_seq (
    .clk      (i_clk),
    .rst      (i_reset),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  // Compare over the full address width so aliases above MEM_SIZE are caught.
  assign in_range = (32'(i_addr) < 32'(MEM_SIZE));
  assign idx      = i_addr[IDX_W-1:0];
  assign cpu_we   = !busy && i_wr && in_range && (|i_be);
  assign cpu_rd   = !busy && i_rd && in_range;

  // Merge enabled lanes into the current word so one whole-word store suffices.
  always_comb begin
    wmerge = mem[idx];
    for (int k = 0; k < LANES; k++) begin
      if (i_be[k]) begin
        wmerge[k*LANE_WIDTH +: LANE_WIDTH] = i_data[k*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // The clear port owns the array while busy; CPU writes are locked out then.
  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (cpu_we) begin
      mem[idx] <= wmerge;
    end
  end

  // ---- stage p0 -> p1: registered read (read-first against a same-cycle write)
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_p1   <= 1'b0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1   <= !busy && i_rd;
      err_p1   <= !busy && (i_wr || i_rd) && !in_range;
      rdata_p1 <= cpu_rd ? mem[idx] : '0;
    end
  end

  assign o_data  = rdata_p1;
  assign o_valid = vld_p1;
  assign o_err   = err_p1;
  assign o_busy  = busy;

endmodule

// File: tb/tb_dm_ram_sync.sv
module tb_dm_ram_sync;

  localparam int MS = 16;
  localparam int AL = 11;
  localparam int DL = 16;
  localparam int LW = 8;
  localparam int NL = DL / LW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AL-1:0] addr;
  logic          wr, rd;
  logic [NL-1:0] be;
  logic [DL-1:0] din;
  logic [DL-1:0] dout;
  logic          vld, busy, err;

  logic          n_rst;
  logic [AL-1:0] n_addr;
  logic          n_wr, n_rd;
  logic [NL-1:0] n_be;
  logic [DL-1:0] n_din;
  logic [DL-1:0] n_dout;
  logic          n_vld, n_busy, n_err;

  dm_ram_sync #(
    .MEM_SIZE(MS), .ADDR_LENGTH(AL), .DATA_LENGTH(DL), .LANE_WIDTH(LW), .CLEAR_ON_RESET(1)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_wr(wr), .i_rd(rd), .i_be(be),
    .i_data(din), .o_data(dout), .o_valid(vld), .o_busy(busy), .o_err(err)
  );

  dm_ram_sync #(
    .MEM_SIZE(MS), .ADDR_LENGTH(AL), .DATA_LENGTH(DL), .LANE_WIDTH(LW), .CLEAR_ON_RESET(0)
  ) dut_nc (
    .i_clk(clk), .i_reset(n_rst), .i_addr(n_addr), .i_wr(n_wr), .i_rd(n_rd), .i_be(n_be),
    .i_data(n_din), .o_data(n_dout), .o_valid(n_vld), .o_busy(n_busy), .o_err(n_err)
  );

  int tests = 0;
  int fails = 0;
  logic [DL-1:0] model [MS];

  typedef struct {
    logic          w;
    logic          r;
    logic [AL-1:0] a;
    logic [NL-1:0] b;
    logic [DL-1:0] d;
    logic          ev;
    logic [DL-1:0] ed;
    logic          ee;
  } vec_t;

  vec_t vt [14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr = 1'b0; rd = 1'b0; addr = '0; be = '0; din = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < MS; i++) model[i] = '0;
  endtask

  // Reference: a read returns the word as it was before this cycle's write;
  // any request beyond the implemented words flags an error and never stores.
  task automatic model_op(input logic w, input logic r, input logic [AL-1:0] a,
                          input logic [NL-1:0] b, input logic [DL-1:0] d,
                          output logic ev, output logic [DL-1:0] ed, output logic ee);
    int  ai;
    bit  hit;
    ai  = int'(a);
    hit = (ai < MS);
    ee  = (w || r) && !hit;
    ev  = r;
    ed  = (r && hit) ? model[ai] : '0;
    if (w && hit) begin
      for (int k = 0; k < NL; k++) begin
        if (b[k]) model[ai][k*LW +: LW] = d[k*LW +: LW];
      end
    end
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic rand_op(input int i);
    logic          w, r, ev, ee;
    logic [AL-1:0] a;
    logic [NL-1:0] b;
    logic [DL-1:0] d, ed;
    w = ($urandom_range(0, 2) == 0);
    r = ($urandom_range(0, 1) == 0);
    a = AL'($urandom_range(0, 23));
    b = NL'($urandom_range(0, 3));
    d = DL'($urandom);
    wr = w; rd = r; addr = a; be = b; din = d;
    tick();
    model_op(w, r, a, b, d, ev, ed, ee);
    check($sformatf("rand%0d_vld", i), 32'(vld), 32'(ev));
    check($sformatf("rand%0d_data", i), 32'(dout), 32'(ed));
    check($sformatf("rand%0d_err", i), 32'(err), 32'(ee));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    logic          ev, ee;
    logic [DL-1:0] ed;

    rst = 1'b1; n_rst = 1'b1;
    idle_in();
    n_wr = 1'b0; n_rd = 1'b0; n_addr = '0; n_be = '0; n_din = '0;
    repeat (2) tick();

    // Reset state
    check("rst_data", 32'(dout), 32'h0);
    check("rst_vld", 32'(vld), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("nc_rst_busy", 32'(n_busy), 32'h0);

    // Clear length and contents after clear
    rst = 1'b0; n_rst = 1'b0;
    wait_clear(n);
    check("clear_len", 32'(n), 32'd16);
    for (int a = 0; a < MS; a++) begin
      rd = 1'b1; addr = AL'(a);
      tick();
      check($sformatf("clr_vld%0d", a), 32'(vld), 32'h1);
      check($sformatf("clr_data%0d", a), 32'(dout), 32'h0);
    end
    idle_in();
    tick();
    check("idle_vld", 32'(vld), 32'h0);
    clear_model();

    // Directed vector table
    vt[0]  = '{1'b1, 1'b0, 11'd3,  2'b11, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 11'd3,  2'b01, 16'h1234, 1'b0, 16'h0000, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 11'd3,  2'b00, 16'h0000, 1'b1, 16'hBE34, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 11'd5,  2'b11, 16'h00AA, 1'b0, 16'h0000, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 11'd5,  2'b11, 16'h5555, 1'b1, 16'h00AA, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 11'd5,  2'b00, 16'h0000, 1'b1, 16'h5555, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 11'd20, 2'b00, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 11'd16, 2'b11, 16'hFFFF, 1'b0, 16'h0000, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 11'd0,  2'b00, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 11'd7,  2'b00, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
    vt[10] = '{1'b0, 1'b1, 11'd7,  2'b00, 16'h0000, 1'b1, 16'h0000, 1'b0};
    vt[11] = '{1'b1, 1'b0, 11'd7,  2'b10, 16'hAB12, 1'b0, 16'h0000, 1'b0};
    vt[12] = '{1'b0, 1'b1, 11'd7,  2'b00, 16'h0000, 1'b1, 16'hAB00, 1'b0};
    vt[13] = '{1'b0, 1'b0, 11'd0,  2'b00, 16'h0000, 1'b0, 16'h0000, 1'b0};
    for (int i = 0; i < 14; i++) begin
      wr = vt[i].w; rd = vt[i].r; addr = vt[i].a; be = vt[i].b; din = vt[i].d;
      tick();
      model_op(vt[i].w, vt[i].r, vt[i].a, vt[i].b, vt[i].d, ev, ed, ee);
      check($sformatf("vec%0d_vld", i), 32'(vld), 32'(vt[i].ev));
      check($sformatf("vec%0d_data", i), 32'(dout), 32'(vt[i].ed));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].ee));
    end
    idle_in();

    // Reset during a pending read cancels o_valid at once
    rd = 1'b1; addr = AL'(3);
    tick();
    check("preread_vld", 32'(vld), 32'h1);
    rst = 1'b1;
    #1;
    check("cancel_vld", 32'(vld), 32'h0);
    check("cancel_data", 32'(dout), 32'h0);
    check("cancel_busy", 32'(busy), 32'h1);
    idle_in();
    tick();
    rst = 1'b0;

    // Reset mid-clear restarts the full clear; requests while busy are ignored
    repeat (7) tick();
    check("midclr_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      wr = 1'b1; rd = 1'b1; addr = '0; be = 2'b11; din = 16'hFFFF;
      tick();
      n++;
      check($sformatf("busy%0d_vld", n), 32'(vld), 32'h0);
      check($sformatf("busy%0d_err", n), 32'(err), 32'h0);
    end
    idle_in();
    check("reclear_len", 32'(n), 32'd16);
    clear_model();
    rd = 1'b1; addr = AL'(0);
    tick();
    check("reclr_a0_vld", 32'(vld), 32'h1);
    check("reclr_a0_data", 32'(dout), 32'h0);
    addr = AL'(3);
    tick();
    check("reclr_a3_data", 32'(dout), 32'h0);
    idle_in();
    tick();

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) rand_op(i);
    idle_in();
    tick();

    // No-clear instance: contents survive reset, busy never rises
    n_wr = 1'b1; n_addr = AL'(1); n_be = 2'b11; n_din = 16'h0042;
    tick();
    n_wr = 1'b0; n_be = '0; n_din = '0;
    n_rst = 1'b1;
    #1;
    check("nc_pulse_busy", 32'(n_busy), 32'h0);
    tick();
    n_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("nc_busy%0d", i), 32'(n_busy), 32'h0);
    end
    n_rd = 1'b1; n_addr = AL'(1);
    tick();
    check("nc_read_vld", 32'(n_vld), 32'h1);
    check("nc_read_data", 32'(n_dout), 32'h0042);
    n_rd = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
